carry_resolver: RTL and testbench

// Downstream of the 3-stage arithmetic encoder. Consumes 0/1/2 pre-carry

---
 rtl/carry_resolver_if.sv | 27 ++
 rtl/carry_resolver.sv | 188 ++++++++++++++++++
 tb/tb_carry_resolver.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/carry_resolver_if.sv
// Handshake bundle between the arithmetic encoder, the carry resolver and the byte sink.
// The pre-carry word width travels with the bundle; only bits [8:0] carry meaning.
interface carry_resolver_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_flag;
  logic [WORD_WIDTH-1:0] in_bit_1;
  logic [WORD_WIDTH-1:0] in_bit_2;
  logic                  flush;
  logic [7:0]            out_byte;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush_done;
  logic                  run_ovf;

  modport master (
    output in_valid, in_flag, in_bit_1, in_bit_2, flush, out_ready,
    input  in_ready, out_byte, out_valid, flush_done, run_ovf
  );

  modport slave (
    input  in_valid, in_flag, in_bit_1, in_bit_2, flush, out_ready,
    output in_ready, out_byte, out_valid, flush_done, run_ovf
  );
endinterface

// File: rtl/carry_resolver.sv
// Resolves encoder carries using one held byte plus a count of pending 0xFF bytes,
// and releases bytes in order once no later carry can change them.
module carry_resolver #(
  parameter int RUN_WIDTH = 16,
  parameter int QDEPTH    = 4
) (
  input logic             general_clk,
  input logic             reset,
  carry_resolver_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ROOM_LIMIT = CW'(QDEPTH - 2);

  typedef enum logic [1:0] {IDLE, EMIT, FLUSH, DONE} state_t;

  state_t               state;
  logic [8:0]           queue [QDEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [7:0]           held;
  logic                 held_v;
  logic [RUN_WIDTH-1:0] run;
  logic [RUN_WIDTH-1:0] remain;
  logic [7:0]           fill;
  logic                 flush_pend;

  logic                 accept;
  logic                 pop;
  logic                 take_flush;
  logic [1:0]           push_n;
  logic [8:0]           word;
  logic                 carry;
  logic [7:0]           bumped;
  logic                 list_go;
  logic [7:0]           list_first;
  logic [7:0]           list_fill;
  logic [RUN_WIDTH-1:0] list_remain;
  logic [7:0]           next_held;
  logic [RUN_WIDTH-1:0] next_run;
  logic                 ovf_set;

  // Two free slots are required so a two-word beat can never be split.
  assign bus.in_ready = (count <= ROOM_LIMIT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign take_flush   = (state == IDLE) && (count == '0) && (bus.flush || flush_pend);
  assign word         = queue[rd_ptr];

  always_comb begin
    push_n = 2'd0;
    if (accept) begin
      case (bus.in_flag)
        2'b01:   push_n = 2'd1;
        2'b10:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
  end

  always_ff @(posedge general_clk) begin
    if (push_n != 2'd0) queue[wr_ptr] <= bus.in_bit_1[8:0];
    if (push_n == 2'd2) queue[wr_ptr + PW'(1)] <= bus.in_bit_2[8:0];
  end

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_n) - CW'(pop);
    end
  end

  // Carry then byte for the word at the queue head, folded into one emit list:
  // a first byte followed by 'list_remain' copies of a fill byte.
  always_comb begin
    carry       = word[8] && held_v;
    bumped      = carry ? held + 8'd1 : held;
    list_go     = 1'b0;
    list_first  = bumped;
    list_fill   = 8'hFF;
    list_remain = '0;
    next_held   = held;
    next_run    = run;
    ovf_set     = 1'b0;
    if (!held_v) begin
      next_held = word[7:0];
    end else if (carry && (run != '0)) begin
      list_go    = 1'b1;
      list_first = held + 8'd1;
      list_fill  = 8'h00;
      if (word[7:0] == 8'hFF) begin
        list_remain = run - RUN_WIDTH'(1);
        next_held   = 8'h00;
        next_run    = RUN_WIDTH'(1);
      end else begin
        list_remain = run;
        next_held   = word[7:0];
        next_run    = '0;
      end
    end else if (word[7:0] == 8'hFF) begin
      next_held = bumped;
      if (&run) ovf_set = 1'b1;
      else      next_run = run + RUN_WIDTH'(1);
    end else begin
      list_go     = 1'b1;
      list_remain = run;
      next_held   = word[7:0];
      next_run    = '0;
    end
  end

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      held           <= 8'h00;
      held_v         <= 1'b0;
      run            <= '0;
      remain         <= '0;
      fill           <= 8'h00;
      flush_pend     <= 1'b0;
      bus.out_byte   <= 8'h00;
      bus.out_valid  <= 1'b0;
      bus.flush_done <= 1'b0;
      bus.run_ovf    <= 1'b0;
    end else begin
      bus.flush_done <= 1'b0;
      if (bus.flush && !take_flush) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            held   <= next_held;
            held_v <= 1'b1;
            run    <= next_run;
            if (ovf_set) bus.run_ovf <= 1'b1;
            if (list_go) begin
              bus.out_valid <= 1'b1;
              bus.out_byte  <= list_first;
              fill          <= list_fill;
              remain        <= list_remain;
              state         <= EMIT;
            end
          end else if (take_flush) begin
            flush_pend <= 1'b0;
            state      <= FLUSH;
            if (held_v) begin
              bus.out_valid <= 1'b1;
              bus.out_byte  <= held;
              fill          <= 8'hFF;
              remain        <= run;
            end
          end
        end
        EMIT, FLUSH: begin
          // A flush with nothing held has no bytes and goes straight to DONE.
          if (!bus.out_valid) begin
            state          <= DONE;
            bus.flush_done <= 1'b1;
          end else if (bus.out_ready) begin
            if (remain != '0) begin
              bus.out_byte <= fill;
              remain       <= remain - RUN_WIDTH'(1);
            end else begin
              bus.out_valid <= 1'b0;
              if (state == FLUSH) begin
                state          <= DONE;
                bus.flush_done <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        DONE: begin
          held_v <= 1'b0;
          run    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_carry_resolver.sv
// Bench for carry_resolver: directed scenarios plus randomized word streams, scored
// against a model that treats the pending bytes as one number receiving the carries.
module tb_carry_resolver;
  logic general_clk = 1'b0;
  logic reset;

  carry_resolver_if #(.WORD_WIDTH(16)) bus ();

  carry_resolver #(.RUN_WIDTH(4), .QDEPTH(4)) dut (
    .general_clk(general_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 general_clk = ~general_clk;

  int         vector_count = 0;
  int         miss_count   = 0;
  int         cyc          = 0;
  int         last_acc     = 0;
  int         done_count   = 0;
  int         ready_mode   = 0;
  bit         expect_gap   = 1'b0;
  bit         prev_stall   = 1'b0;
  logic [7:0] prev_byte    = 8'h00;
  logic [7:0] pending [$];
  logic [7:0] expq [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Carry adds one to the not-yet-final bytes read as a big-endian number; overflow is lost.
  function automatic void modelWord(input logic [15:0] w);
    int i;
    if (w[8] && pending.size() > 0) begin
      i = pending.size() - 1;
      while (i >= 0) begin
        pending[i] = pending[i] + 8'd1;
        if (pending[i] != 8'h00) break;
        i--;
      end
    end
    if (w[7:0] != 8'hFF) begin
      foreach (pending[k]) expq.push_back(pending[k]);
      pending.delete();
    end
    pending.push_back(w[7:0]);
  endfunction

  function automatic void modelFlush();
    foreach (pending[k]) expq.push_back(pending[k]);
    pending.delete();
  endfunction

  function automatic logic [15:0] randWord();
    logic [15:0] w;
    w    = 16'($urandom);
    w[8] = ($urandom_range(0, 2) == 0);
    if ($urandom_range(0, 3) == 0) w[7:0] = 8'hFF;
    return w;
  endfunction

  task automatic applyStimulus(input logic [1:0] flag, input logic [15:0] w1, input logic [15:0] w2);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 500) begin
      @(posedge general_clk); #1;
      guard++;
    end
    if (guard >= 500) checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_flag  = flag;
    bus.in_bit_1 = w1;
    bus.in_bit_2 = w2;
    if (bus.in_ready) begin
      if (flag == 2'b01 || flag == 2'b10) modelWord(w1);
      if (flag == 2'b10) modelWord(w2);
    end
    @(posedge general_clk); #1;
    bus.in_valid = 1'b0;
    bus.in_flag  = 2'b00;
  endtask

  task automatic applyFlush();
    int start;
    int guard;
    start      = done_count;
    guard      = 0;
    expect_gap = (pending.size() > 0);
    modelFlush();
    bus.flush = 1'b1;
    @(posedge general_clk); #1;
    bus.flush = 1'b0;
    while (done_count == start && guard < 2000) begin
      @(posedge general_clk); #1;
      guard++;
    end
    checkOutput("flush_done_count", 32'(done_count - start), 32'd1);
    checkOutput("flush_drained", 32'(expq.size()), 32'd0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    #1;
    pending.delete();
    expq.delete();
    expect_gap = 1'b0;
    repeat (2) @(posedge general_clk);
    #1;
    reset = 1'b0;
    @(posedge general_clk); #1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge general_clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = !bus.out_ready;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  always @(posedge general_clk) cyc++;

  // Scoreboard, output-stability and flush_done timing checks.
  always @(negedge general_clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_byte", 32'(bus.out_byte), 32'(prev_byte));
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("byte_expected", (expq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (expq.size() > 0) checkOutput("out_byte", 32'(bus.out_byte), 32'(expq.pop_front()));
        last_acc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_byte  = bus.out_byte;
      if (bus.flush_done) begin
        done_count++;
        if (expect_gap) checkOutput("flush_done_gap", 32'(cyc - last_acc), 32'd1);
        expect_gap = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d miscompares so far", miss_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int guard;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_flag  = 2'b00;
    bus.in_bit_1 = 16'h0;
    bus.in_bit_2 = 16'h0;
    bus.flush    = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_byte", 32'(bus.out_byte), 32'd0);
    checkOutput("rst_flush_done", 32'(bus.flush_done), 32'd0);
    checkOutput("rst_run_ovf", 32'(bus.run_ovf), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    applyReset();

    $display("[TB] basic pair with latency check");
    ready_mode = 0;
    applyStimulus(2'b10, 16'h0012, 16'h0034);
    @(posedge general_clk); #1;
    checkOutput("lat_held_only", 32'(bus.out_valid), 32'd0);
    @(posedge general_clk); #1;
    checkOutput("lat_first_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lat_first_byte", 32'(bus.out_byte), 32'h12);
    applyFlush();

    $display("[TB] carry ripples through a run");
    applyStimulus(2'b10, 16'h0012, 16'h00FF);
    applyStimulus(2'b10, 16'h00FF, 16'h0105);
    applyFlush();

    $display("[TB] carry with empty run and leading carry");
    applyStimulus(2'b10, 16'h00AB, 16'h0150);
    applyFlush();
    applyStimulus(2'b01, 16'h0170, 16'h0000);
    applyFlush();

    $display("[TB] two-word beat with toggling out_ready");
    ready_mode = 2;
    applyStimulus(2'b10, 16'h0011, 16'h0022);
    applyStimulus(2'b11, 16'h0033, 16'h0044);
    applyFlush();

    $display("[TB] full queue ignores input");
    ready_mode = 3;
    guard = 0;
    while (bus.in_ready && guard < 20) begin
      applyStimulus(2'b10, 16'(2 * guard + 1), 16'(2 * guard + 2));
      guard++;
    end
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_flag  = 2'b10;
    bus.in_bit_1 = 16'h00EE;
    bus.in_bit_2 = 16'h01EE;
    @(posedge general_clk); #1;
    bus.in_valid = 1'b0;
    bus.in_flag  = 2'b00;
    ready_mode = 0;
    applyFlush();

    $display("[TB] randomized streams");
    for (int blk = 0; blk < 25; blk++) begin
      ready_mode = $urandom_range(0, 2);
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
        applyStimulus(2'($urandom_range(0, 3)), randWord(), randWord());
        if ($urandom_range(0, 3) == 0) begin
          @(posedge general_clk); #1;
        end
      end
      applyFlush();
    end
    checkOutput("random_ovf_clear", 32'(bus.run_ovf), 32'd0);

    $display("[TB] reset in the middle of an emit");
    ready_mode = 3;
    applyStimulus(2'b10, 16'h0012, 16'h00FF);
    applyStimulus(2'b10, 16'h00FF, 16'h00FF);
    applyStimulus(2'b01, 16'h0034, 16'h0000);
    repeat (6) @(posedge general_clk);
    #1;
    checkOutput("mid_emit_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("mid_emit_byte", 32'(bus.out_byte), 32'h12);
    start = done_count;
    reset = 1'b1;
    #1;
    checkOutput("reset_drops_valid", 32'(bus.out_valid), 32'd0);
    pending.delete();
    expq.delete();
    expect_gap = 1'b0;
    ready_mode = 0;
    repeat (2) @(posedge general_clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge general_clk);
    #1;
    checkOutput("reset_no_flush_done", 32'(done_count - start), 32'd0);
    checkOutput("reset_idle_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(2'b01, 16'h0056, 16'h0000);
    applyFlush();

    $display("[TB] run counter saturation");
    applyReset();
    applyStimulus(2'b01, 16'h0012, 16'h0000);
    for (int i = 0; i < 7; i++) applyStimulus(2'b10, 16'h00FF, 16'h02FF);
    applyStimulus(2'b01, 16'hE0FF, 16'h0000);
    repeat (8) @(posedge general_clk);
    #1;
    checkOutput("run_full_no_ovf", 32'(bus.run_ovf), 32'd0);
    applyStimulus(2'b01, 16'h00FF, 16'h0000);
    repeat (8) @(posedge general_clk);
    #1;
    checkOutput("run_ovf_set", 32'(bus.run_ovf), 32'd1);
    repeat (4) @(posedge general_clk);
    #1;
    checkOutput("run_ovf_sticky", 32'(bus.run_ovf), 32'd1);
    applyReset();
    checkOutput("run_ovf_reset", 32'(bus.run_ovf), 32'd0);
    checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end
endmodule
